// File: rtl/rgb_blink_sequencer.sv
// rgb_blink_sequencer: drives the RGB LED through N red blinks, gap, N green
// blinks, gap, N blue blinks, gap, then wraps. All phases are timed in
// prescaled ticks. Optional feature macro: RGB_PWM_EN (PWM brightness on lit LED).
module rgb_blink_sequencer #(
    parameter int unsigned TICK_DIV  = 1200,
    parameter int unsigned ON_TICKS  = 2000,
    parameter int unsigned OFF_TICKS = 2000,
    parameter int unsigned GAP_TICKS = 5000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] blink_cnt,
    input  logic [2:0] color_mask,
    input  logic [7:0] bright,
    output logic       busy,
    output logic [1:0] color_sel,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       cycle_done
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0] phase, phase_nxt;
    logic [CNT_W-1:0] phase_last;
    logic [3:0]       remaining, remaining_nxt;
    logic [1:0]       color_nxt;
    logic             busy_nxt;
    logic             led_r_nxt, led_g_nxt, led_b_nxt;
    logic             cycle_done_nxt;
    logic             tick;
    logic             expire;
    logic             pwm_gate;
    logic [2:0]       above;

    // Lowest enabled colour in a mask (caller guarantees mask != 0 when it matters)
    function automatic logic [1:0] lowest_col(input logic [2:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else           return 2'd2;
    endfunction

    // Next enabled colour above c: {found, colour}
    function automatic logic [2:0] above_col(input logic [1:0] c, input logic [2:0] m);
        logic [2:0] r;
        r = 3'b000;
        case (c)
            2'd0: begin
                if (m[1])      r = 3'b101;
                else if (m[2]) r = 3'b110;
            end
            2'd1: begin
                if (m[2])      r = 3'b110;
            end
            default: r = 3'b000;
        endcase
        return r;
    endfunction

`ifdef RGB_PWM_EN
    logic [7:0] pwm_cnt;

    // Free-running PWM counter, independent of phase timing
    always_ff @(posedge clk) begin
        if (rst) pwm_cnt <= 8'd0;
        else     pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign pwm_gate = (pwm_cnt < bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign pwm_gate      = 1'b1;
`endif

    assign tick   = (presc == TICK_LAST);
    assign above  = above_col(color_sel, color_mask);
    assign expire = tick && (phase == phase_last);

    // Tick count at which the current phase ends
    always_comb begin
        phase_last = CNT_ZERO;
        case (state)
            ST_ON:   phase_last = ON_LAST;
            ST_OFF:  phase_last = OFF_LAST;
            ST_GAP:  phase_last = GAP_LAST;
            default: phase_last = CNT_ZERO;
        endcase
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nxt      = state;
        presc_nxt      = tick ? CNT_ZERO : presc + CNT_ONE;
        phase_nxt      = tick ? phase + CNT_ONE : phase;
        remaining_nxt  = remaining;
        color_nxt      = color_sel;
        cycle_done_nxt = 1'b0;

        if (!en) begin
            state_nxt     = ST_IDLE;
            color_nxt     = 2'd0;
            remaining_nxt = 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (blink_cnt != 4'd0 && color_mask != 3'd0) begin
                        state_nxt     = ST_ON;
                        color_nxt     = lowest_col(color_mask);
                        remaining_nxt = blink_cnt;
                    end
                end
                ST_ON: begin
                    if (expire) begin
                        remaining_nxt = 4'(remaining - 4'd1);
                        state_nxt     = (remaining == 4'd1) ? ST_GAP : ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (expire) state_nxt = ST_ON;
                end
                ST_GAP: begin
                    if (expire) begin
                        cycle_done_nxt = ~above[2];
                        remaining_nxt  = blink_cnt;
                        if (blink_cnt == 4'd0 || color_mask == 3'd0) begin
                            state_nxt = ST_IDLE;
                            color_nxt = 2'd0;
                        end else begin
                            state_nxt = ST_ON;
                            color_nxt = above[2] ? above[1:0] : lowest_col(color_mask);
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Timing restarts on every state entry and is held at zero in IDLE
        if (state_nxt != state || state_nxt == ST_IDLE) begin
            presc_nxt = CNT_ZERO;
            phase_nxt = CNT_ZERO;
        end

        busy_nxt  = (state_nxt != ST_IDLE);
        led_r_nxt = (state_nxt == ST_ON) && (color_nxt == 2'd0) && pwm_gate;
        led_g_nxt = (state_nxt == ST_ON) && (color_nxt == 2'd1) && pwm_gate;
        led_b_nxt = (state_nxt == ST_ON) && (color_nxt == 2'd2) && pwm_gate;
    end

    // State, counters and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            presc      <= CNT_ZERO;
            phase      <= CNT_ZERO;
            remaining  <= 4'd0;
            color_sel  <= 2'd0;
            busy       <= 1'b0;
            led_r      <= 1'b0;
            led_g      <= 1'b0;
            led_b      <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            phase      <= phase_nxt;
            remaining  <= remaining_nxt;
            color_sel  <= color_nxt;
            busy       <= busy_nxt;
            led_r      <= led_r_nxt;
            led_g      <= led_g_nxt;
            led_b      <= led_b_nxt;
            cycle_done <= cycle_done_nxt;
        end
    end

endmodule
